fdc_ctrl: RTL and testbench

Floppy disk controller for the IBM PC platform: a µPD765-compatible command/result engine on the ISA I/O bus, with DMA channel 2 and IRQ 6. It implements a command subset and emulates attached media internally, so no drive interface is needed. It serves BIOS and DOS diskette calls.

---
 rtl/fdc_pkg.sv | 41 ++++
 rtl/fdc_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_fdc_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdc_pkg.sv
// Shared constants for the fdc_ctrl floppy controller.
// Covers the port map, opcodes, the command phase type and the status bits.
package fdc_pkg;

    localparam logic [9:0] ADDR_DOR  = 10'h3F2;
    localparam logic [9:0] ADDR_MSR  = 10'h3F4;
    localparam logic [9:0] ADDR_DATA = 10'h3F5;

    localparam logic [4:0] OP_READ    = 5'h06;
    localparam logic [4:0] OP_SPECIFY = 5'h03;
    localparam logic [4:0] OP_RECAL   = 5'h07;
    localparam logic [4:0] OP_SEEK    = 5'h0F;
    localparam logic [4:0] OP_SENSE   = 5'h08;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_CMD    = 2'd1,
        PH_EXEC   = 2'd2,
        PH_RESULT = 2'd3
    } phase_t;

    localparam int MSR_RQM = 7;
    localparam int MSR_DIO = 6;
    localparam int MSR_NDM = 5;
    localparam int MSR_CB  = 4;

    localparam logic [7:0] ST0_INVALID  = 8'h80;
    localparam logic [7:0] ST0_SEEK_END = 8'h20;

    // Number of command bytes, including the opcode. Unknown opcodes take one byte.
    function automatic logic [3:0] cmd_len(input logic [4:0] op);
        case (op)
            OP_READ:    cmd_len = 4'd9;
            OP_SPECIFY: cmd_len = 4'd3;
            OP_RECAL:   cmd_len = 4'd2;
            OP_SEEK:    cmd_len = 4'd3;
            default:    cmd_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/fdc_ctrl.sv
// uPD765-style command/result engine on the ISA bus, with emulated media behind READ DATA.
// The CPU writes commands to DATA, DMA channel 2 streams sector bytes, and results are popped from DATA.
module fdc_ctrl
    import fdc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        irq6,
    output logic        drq2,
    input  logic        dack2_n,
    input  logic        tc,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic [19:0] a,
    inout  wire  [7:0]  d,
    input  logic        aen
);

    phase_t     phase;
    logic       dor_run, dor_irq_en;
    logic [7:0] cmd [0:8];
    logic [3:0] cmd_idx, cmd_need;
    logic [7:0] res [0:6];
    logic [2:0] res_idx, res_cnt;
    logic [7:0] pcn [0:3];
    logic       seek_pend;
    logic [1:0] seek_us;
    logic       irq_r;
    logic [7:0] cyl, sec;
    logic [9:0] byte_k, sec_last;
    logic       byte_ready, xfer_done;
    logic [1:0] prep;

    logic       dma_rd, cpu_rd, cpu_wr, sel_dor, sel_msr, sel_data;
    logic       data_wr, dor_wr, pop, dma_take, eng_rst;
    logic [3:0] wr_need;
    logic [4:0] wr_op;
    logic       wr_last;
    logic [7:0] msr, rd_data;
    logic       drive;
    logic       unused_bits;

    assign sel_dor  = (a[9:0] == ADDR_DOR);
    assign sel_msr  = (a[9:0] == ADDR_MSR);
    assign sel_data = (a[9:0] == ADDR_DATA);

    // A DMA cycle owns the bus whatever the address says.
    assign dma_rd   = !dack2_n && !ior_n;
    assign cpu_rd   = !aen && !ior_n && !dma_rd;
    assign cpu_wr   = !aen && !iow_n;
    assign data_wr  = cpu_wr && sel_data;
    assign dor_wr   = cpu_wr && sel_dor;
    assign pop      = cpu_rd && sel_data && (phase == PH_RESULT);
    assign dma_take = dma_rd && (phase == PH_EXEC) && byte_ready;
    assign eng_rst  = rst || !dor_run || (dor_wr && !d[2]);

    assign wr_op   = (phase == PH_IDLE) ? d[4:0] : cmd[0][4:0];
    assign wr_need = (phase == PH_IDLE) ? cmd_len(d[4:0]) : cmd_need;
    assign wr_last = ((cmd_idx + 4'd1) == wr_need);

    always_comb begin
        sec_last = 10'd1023;
        case (cmd[5])
            8'd0:    sec_last = 10'd127;
            8'd1:    sec_last = 10'd255;
            8'd2:    sec_last = 10'd511;
            default: sec_last = 10'd1023;
        endcase
    end

    always_comb begin
        msr = 8'h00;
        case (phase)
            PH_IDLE:   msr[MSR_RQM] = 1'b1;
            PH_CMD:    begin msr[MSR_RQM] = 1'b1; msr[MSR_CB] = 1'b1; end
            PH_EXEC:   msr[MSR_CB] = 1'b1;
            PH_RESULT: begin msr[MSR_RQM] = 1'b1; msr[MSR_DIO] = 1'b1; msr[MSR_CB] = 1'b1; end
            default:   msr = 8'h00;
        endcase
        msr[MSR_NDM] = 1'b0;
    end

    always_comb begin
        rd_data = 8'h00;
        if (dma_rd)
            rd_data = byte_k[7:0] + sec;
        else if (sel_msr)
            rd_data = msr;
        else if (sel_data && phase == PH_RESULT)
            rd_data = res[res_idx];
    end

    assign drive = dma_rd || (cpu_rd && (sel_msr || sel_data));
    assign d     = drive ? rd_data : 8'hzz;
    assign irq6  = irq_r && dor_irq_en;
    assign drq2  = byte_ready && dor_irq_en && (phase == PH_EXEC);

    assign unused_bits = ^{a[19:10], cmd[7], cmd[8], cmd[0][7:5], cmd[1][7:3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            dor_run    <= 1'b1;
            dor_irq_en <= 1'b1;
        end else if (dor_wr) begin
            dor_run    <= d[2];
            dor_irq_en <= d[3];
        end

        if (eng_rst) begin
            phase      <= PH_IDLE;
            cmd_idx    <= 4'd0;
            cmd_need   <= 4'd0;
            res_idx    <= 3'd0;
            res_cnt    <= 3'd0;
            for (int i = 0; i < 4; i++) pcn[i] <= 8'h00;
            seek_pend  <= 1'b0;
            seek_us    <= 2'd0;
            irq_r      <= 1'b0;
            cyl        <= 8'h00;
            sec        <= 8'h00;
            byte_k     <= 10'd0;
            byte_ready <= 1'b0;
            xfer_done  <= 1'b0;
            prep       <= 2'd0;
        end else begin
            case (phase)
                PH_IDLE, PH_CMD: begin
                    if (data_wr) begin
                        cmd[cmd_idx] <= d;
                        if (!wr_last) begin
                            phase    <= PH_CMD;
                            cmd_idx  <= cmd_idx + 4'd1;
                            cmd_need <= wr_need;
                        end else begin
                            cmd_idx <= 4'd0;
                            res_idx <= 3'd0;
                            phase   <= PH_IDLE;
                            case (wr_op)
                                OP_READ: begin
                                    phase      <= PH_EXEC;
                                    cyl        <= cmd[2];
                                    sec        <= cmd[4];
                                    byte_k     <= 10'd0;
                                    byte_ready <= 1'b0;
                                    xfer_done  <= 1'b0;
                                    prep       <= 2'd2;
                                end
                                OP_SPECIFY: phase <= PH_IDLE;
                                OP_RECAL: begin
                                    pcn[d[1:0]] <= 8'h00;
                                    seek_us     <= d[1:0];
                                    seek_pend   <= 1'b1;
                                    irq_r       <= 1'b1;
                                end
                                OP_SEEK: begin
                                    pcn[cmd[1][1:0]] <= d;
                                    seek_us          <= cmd[1][1:0];
                                    seek_pend        <= 1'b1;
                                    irq_r            <= 1'b1;
                                end
                                OP_SENSE: begin
                                    phase <= PH_RESULT;
                                    irq_r <= 1'b0;
                                    if (seek_pend) begin
                                        res[0]    <= ST0_SEEK_END | {6'd0, seek_us};
                                        res[1]    <= pcn[seek_us];
                                        res_cnt   <= 3'd2;
                                        seek_pend <= 1'b0;
                                    end else begin
                                        res[0]  <= ST0_INVALID;
                                        res_cnt <= 3'd1;
                                    end
                                end
                                default: begin
                                    phase   <= PH_RESULT;
                                    res[0]  <= ST0_INVALID;
                                    res_cnt <= 3'd1;
                                end
                            endcase
                        end
                    end
                end
                PH_EXEC: begin
                    // prep delays the first byte; after each consumed byte the next is ready a cycle later.
                    if (xfer_done) begin
                        phase   <= PH_RESULT;
                        irq_r   <= 1'b1;
                        res[0]  <= {5'd0, cmd[1][2:0]};
                        res[1]  <= 8'h00;
                        res[2]  <= 8'h00;
                        res[3]  <= cyl;
                        res[4]  <= cmd[3];
                        res[5]  <= sec;
                        res[6]  <= cmd[5];
                        res_cnt <= 3'd7;
                        res_idx <= 3'd0;
                    end else if (prep != 2'd0) begin
                        prep <= prep - 2'd1;
                        if (prep == 2'd1) byte_ready <= 1'b1;
                    end else if (dma_take) begin
                        byte_ready <= 1'b0;
                        if (byte_k == sec_last) begin
                            byte_k <= 10'd0;
                            if (sec == cmd[6]) begin
                                sec       <= 8'd1;
                                cyl       <= cyl + 8'd1;
                                xfer_done <= 1'b1;
                            end else begin
                                sec <= sec + 8'd1;
                                if (tc) xfer_done <= 1'b1;
                            end
                        end else begin
                            byte_k <= byte_k + 10'd1;
                            if (tc) xfer_done <= 1'b1;
                        end
                    end else if (!byte_ready) begin
                        byte_ready <= 1'b1;
                    end
                end
                PH_RESULT: begin
                    if (pop) begin
                        irq_r <= 1'b0;
                        if (res_idx == res_cnt - 3'd1) begin
                            phase   <= PH_IDLE;
                            res_idx <= 3'd0;
                        end else begin
                            res_idx <= res_idx + 3'd1;
                        end
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdc_ctrl.sv
// Directed and randomized bench for fdc_ctrl: command/result phases, DMA sector streaming,
// seek interrupts, DOR masking and resets, checked against a sector-arithmetic model.
module tb_fdc_ctrl;

    localparam logic [9:0] P_DOR  = 10'h3F2;
    localparam logic [9:0] P_MSR  = 10'h3F4;
    localparam logic [9:0] P_DATA = 10'h3F5;

    logic        clk = 1'b0;
    logic        rst, irq6, drq2, dack2_n, tc, ior_n, iow_n, aen;
    logic [19:0] a;
    wire  [7:0]  d;
    logic [7:0]  d_drv;
    logic        d_oe;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];
    logic [7:0] dma_q[$];

    logic [7:0] v;
    logic       ok;
    logic [7:0] r_hdus, r_c, r_h, r_r, r_n, r_eot;
    int         r_len, r_total, r_tc;

    assign d = d_oe ? d_drv : 8'hzz;

    always #5 clk = ~clk;

    fdc_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .irq6    (irq6),
        .drq2    (drq2),
        .dack2_n (dack2_n),
        .tc      (tc),
        .ior_n   (ior_n),
        .iow_n   (iow_n),
        .a       (a),
        .d       (d),
        .aen     (aen)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [9:0] addr, input logic [7:0] val);
        @(negedge clk);
        a = {10'd0, addr}; aen = 1'b0; d_drv = val; d_oe = 1'b1; iow_n = 1'b0;
        @(posedge clk); #1;
        iow_n = 1'b1; aen = 1'b1; d_oe = 1'b0;
    endtask

    task automatic io_read(input logic [9:0] addr, output logic [7:0] val);
        @(negedge clk);
        a = {10'd0, addr}; aen = 1'b0; ior_n = 1'b0;
        #1 val = d;
        @(posedge clk); #1;
        ior_n = 1'b1; aen = 1'b1;
    endtask

    task automatic check_msr(input string tag, input logic [7:0] exp);
        logic [7:0] m;
        io_read(P_MSR, m);
        check(tag, m, exp);
    endtask

    // Waits (bounded) for drq2, then performs one DMA read cycle.
    task automatic dma_read(input logic tc_in, output logic [7:0] val, output logic got);
        got = 1'b0;
        val = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (drq2) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            aen = 1'b1; dack2_n = 1'b0; ior_n = 1'b0; tc = tc_in;
            #1 val = d;
            @(posedge clk); #1;
            dack2_n = 1'b1; ior_n = 1'b1; tc = 1'b0;
        end
    endtask

    task automatic pop_results(input string tag);
        logic [7:0] rv;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            io_read(P_DATA, rv);
            check($sformatf("%s_res%0d", tag, k), rv, exp_q.pop_front());
            if (k == 0) check({tag, "_irq_clr"}, {7'd0, irq6}, 8'd0);
            k++;
        end
        check_msr({tag, "_msr_idle"}, 8'h80);
    endtask

    // Sector model: sector length 128<<min(N,3), byte k of sector s is (k+s) mod 256,
    // transfer runs from R through EOT unless tc stops it after byte tc_at.
    task automatic model_read(input logic [7:0] hdus, c, h, r, n, eot, input int tc_at);
        int len, total, t, fin_r, fin_c, st0;
        len   = 128 << ((n > 8'd3) ? 3 : int'(n));
        total = (int'(eot) - int'(r) + 1) * len;
        t     = (tc_at > 0 && tc_at < total) ? tc_at : total;
        dma_q.delete();
        exp_q.delete();
        for (int j = 0; j < t; j++)
            dma_q.push_back(8'((j % len) + int'(r) + j / len));
        if (t == total) begin
            fin_r = 1;
            fin_c = int'(c) + 1;
        end else begin
            fin_r = int'(r) + t / len;
            fin_c = int'(c);
        end
        st0 = int'(hdus[2]) * 4 + int'(hdus[1:0]);
        exp_q.push_back(8'(st0));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(fin_c));
        exp_q.push_back(h);
        exp_q.push_back(8'(fin_r));
        exp_q.push_back(n);
    endtask

    task automatic run_read(input logic [7:0] hdus, c, h, r, n, eot, input int tc_at, input string tag);
        logic [7:0] bv;
        logic       got;
        int         nb;
        nb = dma_q.size();
        io_write(P_DATA, {3'($urandom_range(0, 7)), 5'h06});
        io_write(P_DATA, hdus);
        io_write(P_DATA, c);
        io_write(P_DATA, h);
        io_write(P_DATA, r);
        io_write(P_DATA, n);
        io_write(P_DATA, eot);
        io_write(P_DATA, 8'h2A);
        io_write(P_DATA, 8'hFF);
        check({tag, "_drq_lat0"}, {7'd0, drq2}, 8'd0);
        @(posedge clk); #1;
        check({tag, "_drq_lat1"}, {7'd0, drq2}, 8'd0);
        @(posedge clk); #1;
        check({tag, "_drq_lat2"}, {7'd0, drq2}, 8'd1);
        check_msr({tag, "_msr_exec"}, 8'h10);
        io_write(P_DATA, 8'h08);
        check_msr({tag, "_exec_wr_ignored"}, 8'h10);
        for (int i = 0; i < nb; i++) begin
            dma_read(tc_at == i + 1, bv, got);
            if (!got) begin
                check({tag, "_drq_timeout"}, {7'd0, got}, 8'd1);
                break;
            end
            check($sformatf("%s_byte%0d", tag, i), bv, dma_q[i]);
        end
        check({tag, "_drq_drop"}, {7'd0, drq2}, 8'd0);
        check({tag, "_irq_before_res"}, {7'd0, irq6}, 8'd0);
        @(posedge clk); #1;
        check({tag, "_irq_res"}, {7'd0, irq6}, 8'd1);
        check_msr({tag, "_msr_result"}, 8'hD0);
        pop_results(tag);
    endtask

    initial begin
        rst = 1'b1; dack2_n = 1'b1; tc = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
        aen = 1'b1; a = 20'd0; d_drv = 8'h00; d_oe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_irq", {7'd0, irq6}, 8'd0);
        check("rst_drq", {7'd0, drq2}, 8'd0);
        @(negedge clk);
        a = {10'd0, P_MSR}; aen = 1'b0; d_drv = 8'h5A; d_oe = 1'b1;
        #1 check("rst_bus_released", d, 8'h5A);
        d_oe = 1'b0; aen = 1'b1;
        check_msr("rst_msr", 8'h80);
        io_read(P_DATA, v);
        check("idle_data_read", v, 8'h00);
        check_msr("idle_read_no_change", 8'h80);

        // READ DATA, one sector with R = EOT
        model_read(8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 0);
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        run_read(8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 0, "rd_eot");

        // READ DATA stopped by tc at the end of the first sector
        model_read(8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h09, 512);
        check("rd_tc_len", 8'(dma_q.size() / 4), 8'd128);
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        run_read(8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h09, 512, "rd_tc");

        // SEEK then SENSE INTERRUPT, twice
        io_write(P_DATA, 8'h0F);
        check_msr("seek_msr_cmd", 8'h90);
        io_write(P_DATA, 8'h00);
        io_write(P_DATA, 8'h28);
        check("seek_irq", {7'd0, irq6}, 8'd1);
        check_msr("seek_msr_idle", 8'h80);
        io_write(P_DATA, 8'h08);
        check("sense_irq_clr", {7'd0, irq6}, 8'd0);
        check_msr("sense_msr", 8'hD0);
        exp_q.push_back(8'h20); exp_q.push_back(8'h28);
        pop_results("sense1");
        io_write(P_DATA, 8'h08);
        exp_q.push_back(8'h80);
        pop_results("sense2");

        // Invalid opcode
        io_write(P_DATA, 8'h1F);
        check_msr("inval_msr", 8'hD0);
        exp_q.push_back(8'h80);
        pop_results("inval");

        // SPECIFY has no result phase
        io_write(P_DATA, 8'h03);
        io_write(P_DATA, 8'hDF);
        io_write(P_DATA, 8'h02);
        check("spec_irq", {7'd0, irq6}, 8'd0);
        check_msr("spec_msr", 8'h80);

        // SEEK drive 1, RECALIBRATE drive 1
        io_write(P_DATA, 8'h0F); io_write(P_DATA, 8'h01); io_write(P_DATA, 8'h05);
        io_write(P_DATA, 8'h08);
        exp_q.push_back(8'h21); exp_q.push_back(8'h05);
        pop_results("sense_seek1");
        io_write(P_DATA, 8'h07); io_write(P_DATA, 8'h01);
        check("recal_irq", {7'd0, irq6}, 8'd1);
        io_write(P_DATA, 8'h08);
        exp_q.push_back(8'h21); exp_q.push_back(8'h00);
        pop_results("sense_recal");

        // DOR bit 3 masks irq6 without losing the pending seek
        io_write(P_DOR, 8'h04);
        io_write(P_DATA, 8'h0F); io_write(P_DATA, 8'h02); io_write(P_DATA, 8'h10);
        check("mask_irq_off", {7'd0, irq6}, 8'd0);
        io_write(P_DOR, 8'h0C);
        check("mask_irq_on", {7'd0, irq6}, 8'd1);
        io_write(P_DATA, 8'h08);
        exp_q.push_back(8'h22); exp_q.push_back(8'h10);
        pop_results("sense_mask");

        // rst in the middle of a DMA transfer
        io_write(P_DATA, 8'h0F); io_write(P_DATA, 8'h03); io_write(P_DATA, 8'h33);
        model_read(8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 0);
        io_write(P_DATA, 8'h06); io_write(P_DATA, 8'h00); io_write(P_DATA, 8'h00);
        io_write(P_DATA, 8'h00); io_write(P_DATA, 8'h01); io_write(P_DATA, 8'h00);
        io_write(P_DATA, 8'h01); io_write(P_DATA, 8'h2A); io_write(P_DATA, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            dma_read(1'b0, v, ok);
            check($sformatf("rstdma_byte%0d", i), v, dma_q[i]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstdma_drq", {7'd0, drq2}, 8'd0);
        check("rstdma_irq", {7'd0, irq6}, 8'd0);
        check_msr("rstdma_msr", 8'h80);
        io_write(P_DATA, 8'h08);
        exp_q.delete();
        exp_q.push_back(8'h80);
        pop_results("rstdma_sense");

        // DOR bit 2 = 0 aborts a command and holds the engine
        io_write(P_DATA, 8'h0F); io_write(P_DATA, 8'h01); io_write(P_DATA, 8'h05);
        io_write(P_DATA, 8'h06); io_write(P_DATA, 8'h00); io_write(P_DATA, 8'h00);
        check_msr("dor_msr_cmd", 8'h90);
        io_write(P_DOR, 8'h08);
        check_msr("dor_msr_reset", 8'h80);
        check("dor_irq", {7'd0, irq6}, 8'd0);
        check("dor_drq", {7'd0, drq2}, 8'd0);
        io_write(P_DATA, 8'h08);
        check_msr("dor_held_ignores", 8'h80);
        io_write(P_DOR, 8'h0C);
        check("dor_release_irq", {7'd0, irq6}, 8'd0);
        io_write(P_DATA, 8'h08);
        exp_q.push_back(8'h80);
        pop_results("dor_sense");

        // Randomized READ DATA transfers
        for (int it = 0; it < 4; it++) begin
            r_hdus = 8'($urandom_range(0, 7));
            r_c    = 8'($urandom_range(0, 250));
            r_h    = 8'($urandom_range(0, 1));
            r_n    = 8'($urandom_range(0, 5));
            r_r    = 8'($urandom_range(1, 20));
            r_eot  = (r_n >= 8'd2) ? r_r : 8'(int'(r_r) + $urandom_range(0, 2));
            r_len  = 128 << ((r_n > 8'd3) ? 3 : int'(r_n));
            r_total = (int'(r_eot) - int'(r_r) + 1) * r_len;
            r_tc   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, r_total)) : 0;
            model_read(r_hdus, r_c, r_h, r_r, r_n, r_eot, r_tc);
            run_read(r_hdus, r_c, r_h, r_r, r_n, r_eot, r_tc, $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
